send_fifo_ctrl: RTL and testbench

SEND_FIFO_CTRL -- requirements
Module: send_fifo_ctrl

---
 rtl/send_fifo_pkg.sv | 23 ++
 rtl/sdp_ram.sv | 42 ++++
 rtl/send_fifo_ctrl.sv | 155 +++++++++++++++
 tb/tb_send_fifo_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/send_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : send_fifo_pkg
// Purpose  : Shared constants for the send FIFO controller: the default
//            depth and almost-full threshold, and the output-stage state
//            encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package send_fifo_pkg;

    // Default geometry: 512 words of 64 bytes each.
    localparam int c_DEPTH_DEFAULT       = 512;
    localparam int c_AFULL_LEVEL_DEFAULT = 500;

    // Output stage state encoding.
    localparam int         c_OUT_STATE_W = 2;
    localparam logic [1:0] OUT_EMPTY     = 2'd0;
    localparam logic [1:0] OUT_FETCH     = 2'd1;
    localparam logic [1:0] OUT_VALID     = 2'd2;

endpackage : send_fifo_pkg
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM with one write port and one read port.
//            Reads are registered: data addressed in cycle N appears on
//            rd_data in cycle N+1. Contents are never reset.
// Ports    : clk_sys             - clock
//            wr_en/wr_addr/wr_data - write port
//            rd_en/rd_addr       - read request (read register updates only
//                                  when rd_en is high)
//            rd_data             - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_sys,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : sdp_ram
`default_nettype wire

// File: rtl/send_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : send_fifo_ctrl
// Purpose  : Send FIFO with commit semantics. Written words stay invisible to
//            the consumer until a send_ack pulse commits everything written
//            so far (including a word written in the send_ack cycle). A
//            three-state output stage fetches committed words from the RAM
//            into an output register.
// Ports    : clk_sys, rst_sys    - clock, synchronous active-high reset
//            flush               - level, discards all content
//            s_valid/s_ready/s_data - write side
//            send_ack            - commit pulse
//            m_valid/m_ready/m_data - read side (committed words only)
//            send_fifo_usedw     - occupancy including uncommitted words and
//                                  the word held in the output register
//            almost_full         - registered (usedw >= AFULL_LEVEL), only
//                                  present when SEND_FIFO_AFULL_EN is defined
// Config   : `define SEND_FIFO_AFULL_EN to add the almost_full port.
// Revision : 1.0 - initial release
// ============================================================================
module send_fifo_ctrl
    import send_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = $clog2(c_DEPTH_DEFAULT),
    parameter int AFULL_LEVEL = c_AFULL_LEVEL_DEFAULT
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  send_ack,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [31:0]           send_fifo_usedw
`ifdef SEND_FIFO_AFULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int                 c_PTR_W = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [c_PTR_W-1:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_cmt_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_OUT_STATE_W-1:0] r_state;
    logic [DATA_WIDTH-1:0]    r_m_data;

    logic                     w_wr_fire;
    logic [c_PTR_W-1:0]       w_wr_next;
    logic                     w_has_cmt;
    logic                     w_fetch_go;
    logic                     w_held;
    logic [c_PTR_W-1:0]       w_usedw;
    logic [DATA_WIDTH-1:0]    w_ram_q;

    // rd_ptr advances when a word is fetched, so wr_ptr - rd_ptr counts only
    // RAM slots still occupied; the word in the output register has already
    // left the RAM and does not block a write.
    assign s_ready    = ~rst_sys & ~flush & ((r_wr_ptr - r_rd_ptr) < c_DEPTH);
    assign w_wr_fire  = s_valid & s_ready;
    assign w_wr_next  = w_wr_fire ? (r_wr_ptr + c_ONE) : r_wr_ptr;
    assign w_has_cmt  = (r_rd_ptr != r_cmt_ptr);

    // A fetch starts from EMPTY, or from VALID when the current word is taken.
    assign w_fetch_go = ~flush & w_has_cmt &
                        ((r_state == OUT_EMPTY) |
                         ((r_state == OUT_VALID) & m_ready));

    assign w_held     = (r_state != OUT_EMPTY);
    assign w_usedw    = r_wr_ptr - (r_rd_ptr - {{ADDR_WIDTH{1'b0}}, w_held});

    assign m_valid         = (r_state == OUT_VALID);
    assign m_data          = r_m_data;
    assign send_fifo_usedw = {{(32-c_PTR_W){1'b0}}, w_usedw};

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (w_wr_fire),
        .wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (s_data),
        .rd_en   (w_fetch_go),
        .rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (w_ram_q)
    );

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
            r_state   <= OUT_EMPTY;
            r_m_data  <= '0;
        end else if (flush) begin
            // Output register contents are left as-is; m_valid is low anyway.
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
            r_state   <= OUT_EMPTY;
        end else begin
            r_wr_ptr <= w_wr_next;
            // Commit against the post-write pointer so a same-cycle write
            // is included in the commit.
            if (send_ack) begin
                r_cmt_ptr <= w_wr_next;
            end
            if (w_fetch_go) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case (r_state)
                OUT_EMPTY: begin
                    if (w_fetch_go) begin
                        r_state <= OUT_FETCH;
                    end
                end
                OUT_FETCH: begin
                    r_m_data <= w_ram_q;
                    r_state  <= OUT_VALID;
                end
                OUT_VALID: begin
                    if (m_ready) begin
                        r_state <= w_has_cmt ? OUT_FETCH : OUT_EMPTY;
                    end
                end
                default: r_state <= OUT_EMPTY;
            endcase
        end
    end

`ifdef SEND_FIFO_AFULL_EN
    logic r_almost_full;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (send_fifo_usedw >= 32'(AFULL_LEVEL));
        end
    end

    assign almost_full = r_almost_full;
`endif

endmodule : send_fifo_ctrl
`default_nettype wire

// File: tb/tb_send_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_send_fifo_ctrl
// Purpose  : Self-checking bench for send_fifo_ctrl. A reference model keeps
//            uncommitted and committed words in queues; a monitor pops the
//            committed queue on every consumer handshake and compares data,
//            and a checker compares occupancy (words accepted minus words
//            handed out) every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_send_fifo_ctrl;

    localparam int DW    = 512;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int AFL   = 500;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          send_ack = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [31:0]   send_fifo_usedw;
`ifdef SEND_FIFO_AFULL_EN
    logic          almost_full;
`endif

    send_fifo_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (AFL)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_sys         (rst_sys),
        .flush           (flush),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .send_ack        (send_ack),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .send_fifo_usedw (send_fifo_usedw)
`ifdef SEND_FIFO_AFULL_EN
        ,
        .almost_full     (almost_full)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_wr = 0;
    int            n_rd = 0;
    int            n_pop_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Model: inputs are stable from posedge+1 until the next posedge, so at
    // the falling edge we know exactly what the coming edge will do.
    always @(negedge clk_sys) begin
        if (rst_sys || flush) begin
            pend_q.delete();
            exp_q.delete();
            n_wr = 0;
            n_rd = 0;
        end else begin
            if (s_valid && s_ready) begin
                pend_q.push_back(s_data);
                n_wr++;
            end
            if (send_ack) begin
                while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            end
        end
    end

    // Monitor: any presented word must be the oldest committed one.
    always @(negedge clk_sys) begin
        if (!rst_sys && !flush && m_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL uncommitted_visible: got m_valid=1 want no committed word");
            end else begin
                chk("m_data", m_data, exp_q[0]);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    n_rd++;
                    n_pop_total++;
                end
            end
        end
    end

    // Occupancy and write-readiness checked shortly after each edge.
    always @(posedge clk_sys) begin
        #2;
        if (!rst_sys) begin
            chk("usedw", DW'(send_fifo_usedw), DW'(n_wr - n_rd));
            if (flush) chk("s_ready_flush", DW'(s_ready), DW'(0));
            else if ((n_wr - n_rd) < DEPTH) chk("s_ready_room", DW'(s_ready), DW'(1));
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] d);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk_sys);
        while (!s_ready && t < 600) begin
            @(negedge clk_sys);
            t++;
        end
        if (!s_ready) fail_now("put_timeout");
        tick();
        s_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < lim) begin
            tick();
            t++;
        end
        if (t >= lim) fail_now("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        int pops_before;
        int t;

        // Reset
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_s_ready", DW'(s_ready), DW'(0));
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        tick();
        rst_sys = 1'b0;
        @(negedge clk_sys);
        chk("post_rst_s_ready", DW'(s_ready), DW'(1));
        chk("post_rst_m_valid", DW'(m_valid), DW'(0));
        chk("post_rst_m_data", m_data, DW'(0));
        chk("post_rst_usedw", DW'(send_fifo_usedw), DW'(0));
`ifdef SEND_FIFO_AFULL_EN
        chk("post_rst_afull", DW'(almost_full), DW'(0));
`endif
        tick();

        // Four words written, nothing committed
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(DW'(8'hA0 + i));
        repeat (20) begin
            @(negedge clk_sys);
            chk("no_commit_valid", DW'(m_valid), DW'(0));
        end
        chk("usedw_4", DW'(send_fifo_usedw), DW'(4));
        tick();

        // Commit: m_valid three cycles after the pulse
        ack_pulse();
        @(negedge clk_sys);
        chk("lat_c1", DW'(m_valid), DW'(0));
        tick();
        @(negedge clk_sys);
        chk("lat_c2", DW'(m_valid), DW'(0));
        tick();
        @(negedge clk_sys);
        chk("lat_c3", DW'(m_valid), DW'(1));
        chk("first_word", m_data, DW'(8'hA0));
        tick();
        wait_drain(50);
        @(negedge clk_sys);
        chk("usedw_drained", DW'(send_fifo_usedw), DW'(0));
        tick();

        // Fill to capacity, then commit while full
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) put(rnd_word());
        @(negedge clk_sys);
        chk("full_s_ready", DW'(s_ready), DW'(0));
        chk("full_usedw", DW'(send_fifo_usedw), DW'(DEPTH));
        tick();
        ack_pulse();
        @(negedge clk_sys);
        chk("full_after_ack_s_ready", DW'(s_ready), DW'(0));
        tick();
        @(negedge clk_sys);
        chk("reopen_s_ready", DW'(s_ready), DW'(1));
        chk("reopen_usedw", DW'(send_fifo_usedw), DW'(DEPTH));
        tick();
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 4000) begin
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
            t++;
        end
        if (t >= 4000) fail_now("full_drain_timeout");
        m_ready = 1'b0;

        // Long random stream with periodic commits; pointers wrap
        pops_before = n_pop_total;
        sent = 0;
        cyc  = 0;
        while (sent < 1500 && cyc < 20000) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = rnd_word();
            m_ready  = ($urandom_range(0, 3) != 0);
            send_ack = (cyc % 23 == 0);
            if (sent == 1499) s_valid = 1'b1;
            @(negedge clk_sys);
            if (s_valid && s_ready) sent++;
            tick();
            cyc++;
        end
        if (sent < 1500) fail_now("stream_timeout");
        s_valid = 1'b0;
        m_ready = 1'b1;
        ack_pulse();
        wait_drain(4000);
        chk("stream_count", DW'(n_pop_total - pops_before), DW'(1500));

        // Flush while a word is presented
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) put(rnd_word());
        ack_pulse();
        t = 0;
        while (!m_valid && t < 20) begin
            tick();
            t++;
        end
        if (!m_valid) fail_now("flush_setup_timeout");
        flush = 1'b1;
        tick();
        @(negedge clk_sys);
        chk("flush_m_valid", DW'(m_valid), DW'(0));
        chk("flush_usedw", DW'(send_fifo_usedw), DW'(0));
        chk("flush_s_ready", DW'(s_ready), DW'(0));
        tick();
        flush = 1'b0;
        @(negedge clk_sys);
        chk("post_flush_s_ready", DW'(s_ready), DW'(1));
        chk("post_flush_m_valid", DW'(m_valid), DW'(0));
        tick();

        // send_ack with nothing new written
        ack_pulse();
        repeat (6) begin
            @(negedge clk_sys);
            chk("empty_ack_m_valid", DW'(m_valid), DW'(0));
        end
        tick();

`ifdef SEND_FIFO_AFULL_EN
        // Almost-full rises one cycle after the 500th write
        for (int i = 0; i < AFL; i++) put(rnd_word());
        @(negedge clk_sys);
        chk("afull_at_500", DW'(almost_full), DW'(0));
        tick();
        @(negedge clk_sys);
        chk("afull_after_500", DW'(almost_full), DW'(1));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_send_fifo_ctrl
`default_nettype wire
